// File: rtl/ctrl_fir_mac_seq.sv
// Sequencer for a polyphase FIR MAC: steps coefficient and sample-ring addresses for one output
// sample and strobes the accumulator so each product is taken one cycle after its RAM read.
module ctrl_fir_mac_seq #(
   parameter int unsigned ADDR_WIDTH      = 12,
   parameter int unsigned DATA_ADDR_WIDTH = 10,
   parameter int unsigned TAPS_WIDTH      = 8
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       start,
   input  logic [ADDR_WIDTH-1:0]      phase_ptr,
   input  logic [TAPS_WIDTH-1:0]      taps,
   input  logic [DATA_ADDR_WIDTH-1:0] data_head,
   output logic                       coef_load,
   output logic                       coef_cnt,
   output logic [ADDR_WIDTH-1:0]      coef_ptr,
   output logic [DATA_ADDR_WIDTH-1:0] data_addr,
   output logic                       rd_en,
   output logic                       mac_clr,
   output logic                       mac_en,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       start_drop
);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StFlush, StDone} state_e;

   state_e                state;
   logic [TAPS_WIDTH-1:0] remaining;
   logic                  mac_clr_q;
   logic                  zero_start;

   // A zero-tap request clears the accumulator in the request cycle itself, since it never
   // passes through LOAD.
   assign zero_start = (state == StIdle) && start && (taps == '0) && !clr;
   assign mac_clr    = mac_clr_q | zero_start;
   assign busy       = (state != StIdle);

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= StIdle;
         remaining  <= '0;
         coef_ptr   <= '0;
         data_addr  <= '0;
         coef_load  <= 1'b0;
         coef_cnt   <= 1'b0;
         rd_en      <= 1'b0;
         mac_clr_q  <= 1'b0;
         mac_en     <= 1'b0;
         out_valid  <= 1'b0;
         start_drop <= 1'b0;
      end else begin
         coef_load  <= 1'b0;
         coef_cnt   <= 1'b0;
         rd_en      <= 1'b0;
         mac_clr_q  <= 1'b0;
         mac_en     <= 1'b0;
         out_valid  <= 1'b0;
         start_drop <= start && (state != StIdle);
         unique case (state)
            StIdle: begin
               if (start) begin
                  if (taps != '0) begin
                     state     <= StLoad;
                     coef_ptr  <= phase_ptr;
                     data_addr <= data_head;
                     remaining <= taps;
                     coef_load <= 1'b1;
                     mac_clr_q <= 1'b1;
                  end else begin
                     state     <= StDone;
                     out_valid <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state    <= StRun;
               rd_en    <= 1'b1;
               coef_cnt <= (remaining != TAPS_WIDTH'(1));
            end
            StRun: begin
               // Every read is followed by exactly one accumulate, including the last (in FLUSH).
               mac_en <= 1'b1;
               if (remaining == TAPS_WIDTH'(1)) begin
                  state <= StFlush;
               end else begin
                  rd_en     <= 1'b1;
                  remaining <= remaining - TAPS_WIDTH'(1);
                  data_addr <= data_addr - DATA_ADDR_WIDTH'(1);
                  coef_cnt  <= (remaining != TAPS_WIDTH'(2));
               end
            end
            StFlush: begin
               state     <= StDone;
               out_valid <= 1'b1;
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_fir_mac_seq.sv
// Scoreboard bench for ctrl_fir_mac_seq: expected reads and completion records are queued when a
// request is driven and checked as the sequencer produces them.
module tb_ctrl_fir_mac_seq;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic [11:0] phase_ptr = '0;
   logic [7:0]  taps = '0;
   logic [9:0]  data_head = '0;
   logic        coef_load, coef_cnt, rd_en, mac_clr, mac_en, out_valid, busy, start_drop;
   logic [11:0] coef_ptr;
   logic [9:0]  data_addr;

   ctrl_fir_mac_seq dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .phase_ptr  (phase_ptr),
      .taps       (taps),
      .data_head  (data_head),
      .coef_load  (coef_load),
      .coef_cnt   (coef_cnt),
      .coef_ptr   (coef_ptr),
      .data_addr  (data_addr),
      .rd_en      (rd_en),
      .mac_clr    (mac_clr),
      .mac_en     (mac_en),
      .out_valid  (out_valid),
      .busy       (busy),
      .start_drop (start_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] ca;
      logic [9:0]  da;
   } rd_t;

   typedef struct {
      int cyc;
      int n_mac;
      int n_cnt;
      int n_busy;
   } done_t;

   rd_t   rd_q[$];
   done_t done_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_mac, n_cnt, n_busy, misalign, overlap, drops;
   logic [11:0] ca_m = '0;
   logic        rd_prev = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: models the external coefficient counter and checks every read and completion.
   always @(negedge clk) begin
      rd_t   e;
      done_t d;
      if (start_drop) drops++;
      if (!busy) begin
         n_mac = 0; n_cnt = 0; n_busy = 0; misalign = 0; overlap = 0;
      end else begin
         n_busy++;
         if (mac_en) n_mac++;
         if (coef_cnt) n_cnt++;
         if (mac_en != rd_prev) misalign++;
         if (coef_load && coef_cnt) overlap++;
         if (rd_en) begin
            check_eq("rd_pending", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) begin
               e = rd_q.pop_front();
               check_eq("coef_addr", 32'(ca_m), 32'(e.ca));
               check_eq("data_addr", 32'(data_addr), 32'(e.da));
            end
         end
         if (out_valid) begin
            check_eq("done_pending", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) begin
               d = done_q.pop_front();
               check_eq("valid_cycle", 32'(cyc), 32'(d.cyc));
               check_eq("mac_en_count", 32'(n_mac), 32'(d.n_mac));
               check_eq("coef_cnt_count", 32'(n_cnt), 32'(d.n_cnt));
               check_eq("busy_cycles", 32'(n_busy), 32'(d.n_busy));
               check_eq("mac_align", 32'(misalign), 32'd0);
               check_eq("load_cnt_overlap", 32'(overlap), 32'd0);
               check_eq("reads_left", 32'(rd_q.size()), 32'd0);
            end
         end
      end
      if (coef_load) ca_m = coef_ptr;
      else if (coef_cnt) ca_m = ca_m + 12'd1;
      rd_prev = rd_en;
   end

   task automatic start_run(input logic [11:0] p, input logic [7:0] t, input logic [9:0] h);
      rd_t   r;
      done_t d;
      @(posedge clk); #1;
      phase_ptr = p; taps = t; data_head = h; start = 1'b1;
      for (int k = 0; k < int'(t); k++) begin
         r.ca = p + 12'(k);
         r.da = h - 10'(k);
         rd_q.push_back(r);
      end
      d.cyc    = cyc + ((t == 0) ? 1 : int'(t) + 3);
      d.n_mac  = int'(t);
      d.n_cnt  = (t == 0) ? 0 : int'(t) - 1;
      d.n_busy = (t == 0) ? 1 : int'(t) + 3;
      done_q.push_back(d);
      #2;
      if (t == 0) check_eq("zero_mac_clr", 32'(mac_clr), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 600 && (busy || done_q.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      check_eq("idle_timeout", 32'(busy || done_q.size() != 0), 32'd0);
      repeat (3) @(posedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, 32'({coef_load, coef_cnt, rd_en, mac_clr, mac_en, out_valid, busy,
                         start_drop}), 32'd0);
      check_eq({tag, "_ptrs"}, 32'({coef_ptr, data_addr}), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      clr = 1'b0;

      start_run(12'h100, 8'd4, 10'h010);
      wait_idle();
      start_run(12'h0AB, 8'd3, 10'h001);
      wait_idle();
      start_run(12'h7FF, 8'd0, 10'h123);
      wait_idle();
      start_run(12'h001, 8'd1, 10'h000);
      wait_idle();

      // Restart while busy: dropped, first run unaffected.
      start_run(12'h200, 8'd5, 10'h3F0);
      @(posedge clk); #1;
      phase_ptr = 12'hABC; taps = 8'd9; data_head = 10'h155; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("start_drop", 32'(start_drop), 32'd1);
      wait_idle();
      repeat (10) @(posedge clk);

      // Abort in RUN cycle 2 with a simultaneous start that must be neither taken nor dropped.
      start_run(12'h300, 8'd6, 10'h005);
      repeat (3) @(posedge clk);
      #1;
      clr = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; start = 1'b0;
      rd_q.delete();
      done_q.delete();
      check_all_zero("abort");
      @(posedge clk); #1;
      check_eq("abort_idle", 32'({busy, start_drop, out_valid}), 32'd0);

      start_run(12'h050, 8'd2, 10'h3FF);
      wait_idle();
      start_run(12'h0F0, 8'd255, 10'h002);
      wait_idle();

      check_eq("drop_total", 32'(drops), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ctrl_fir_mac_seq.md
CTRL_FIR_MAC_SEQ -- requirements
Module: ctrl_fir_mac_seq

Interface
REQ-001 Parameter: ADDR_WIDTH, default 12, coefficient RAM address width.
REQ-002 Parameter: DATA_ADDR_WIDTH, default 10, sample ring-buffer address width; depth = 2^DATA_ADDR_WIDTH.
REQ-003 Parameter: TAPS_WIDTH, default 8, width of the per-phase tap count.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: clr  in  1  reset; synchronous, active-high.
REQ-006 Port: start  in  1  single-cycle request to compute one output sample.
REQ-007 Port: phase_ptr  in  ADDR_WIDTH  coefficient base address of the selected polyphase branch; sampled on accepted start.
REQ-008 Port: taps  in  TAPS_WIDTH  number of MAC operations for this phase; sampled on accepted start.
REQ-009 Port: data_head  in  DATA_ADDR_WIDTH  ring-buffer address of the newest sample; sampled on accepted start.
REQ-010 Port: coef_load  out  1  load strobe to the coefficient address counter.
REQ-011 Port: coef_cnt  out  1  increment strobe to the coefficient address counter.
REQ-012 Port: coef_ptr  out  ADDR_WIDTH  latched phase_ptr, load value for the counter.
REQ-013 Port: data_addr  out  DATA_ADDR_WIDTH  ring-buffer read address (registered).
REQ-014 Port: rd_en  out  1  read enable for coefficient and sample RAMs.
REQ-015 Port: mac_clr  out  1  clear accumulator.
REQ-016 Port: mac_en  out  1  accumulate current RAM outputs (1-cycle RAM read latency).
REQ-017 Port: out_valid  out  1  one-cycle pulse: accumulator holds finished sample.
REQ-018 Port: busy  out  1  high from accepted start until out_valid cycle inclusive.
REQ-019 Port: start_drop  out  1  one-cycle pulse when start arrives while busy.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, FLUSH, DONE; busy = (state != IDLE).
REQ-021 IDLE: start=1 and taps!=0 -> latch phase_ptr/taps/data_head, go LOAD; start=1 and taps==0 -> go DONE (mac_clr=1 same cycle, no reads); else stay.
REQ-022 LOAD (1 cycle): coef_load=1, mac_clr=1, data_addr=latched data_head, remaining=taps; -> RUN.
REQ-023 RUN cycle k (k=0..taps-1): rd_en=1, data_addr = head - k modulo 2^DATA_ADDR_WIDTH; counter address = phase_ptr + k.
REQ-024 coef_cnt SHALL be 1 in RUN cycles 0..taps-2 and 0 in the last RUN cycle; coef_load and coef_cnt never high together.
REQ-025 data_addr SHALL decrement once per RUN cycle except the last, wrapping 0 -> 2^DATA_ADDR_WIDTH-1.
REQ-026 mac_en SHALL be 1 in RUN cycles 1..taps-1 and in FLUSH: exactly taps cycles, each one cycle after the matching rd_en.
REQ-027 Last RUN cycle -> FLUSH (1 cycle) -> DONE (1 cycle, out_valid=1) -> IDLE.
REQ-028 Latency: accepted start at cycle 0 -> out_valid at cycle taps+3 (taps!=0); taps==0 -> cycle 1.
REQ-029 start while busy SHALL be ignored (latched values unchanged) and pulse start_drop next cycle; start in DONE is also dropped.
REQ-030 Tap counter SHALL be TAPS_WIDTH bits; taps = 2^TAPS_WIDTH-1 SHALL run fully without overflow.

Reset
REQ-031 clr=1 SHALL force IDLE at next edge from any state, aborting any run.
REQ-032 Outputs after reset: coef_load, coef_cnt, rd_en, mac_clr, mac_en, out_valid, busy, start_drop = 0; coef_ptr, data_addr = 0.
REQ-033 clr has priority over start in the same cycle; that start is neither accepted nor dropped.

Verification
REQ-034 start, phase_ptr=0x100, taps=4, head=0x010 -> LOAD, coef addrs 0x100..0x103, data_addr 0x010,0x00F,0x00E,0x00D, 4 mac_en, out_valid at cycle 7.
REQ-035 head=0x001, taps=3 -> data_addr 0x001,0x000,0x3FF (wrap).
REQ-036 taps=0 -> mac_clr at cycle 0, no rd_en/mac_en, out_valid at cycle 1, busy for exactly 1 cycle.
REQ-037 start reasserted during RUN -> start_drop pulse, first run completes unchanged, no second run.
REQ-038 clr asserted in RUN cycle 2 -> all outputs 0 next cycle, no out_valid; fresh start then completes normally.
REQ-039 taps=255 -> 254 coef_cnt pulses, 255 mac_en pulses, out_valid at cycle 258.
